// File: rtl/i2s_tx_if.sv
// Stereo PCM sample-pair handshake between an audio source and i2s_tx.
interface i2s_tx_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] ldata;
    logic [DATA_W-1:0] rdata;
    logic              in_valid;
    logic              in_ready;

    modport master (output ldata, rdata, in_valid, input in_ready);
    modport slave  (input ldata, rdata, in_valid, output in_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: 64-bit frames, 32-bit slots, one-pair holding buffer.
// Define I2S_TX_HOLD_LAST_EN to repeat the last pair on underrun; otherwise underrun frames are muted.
module i2s_tx #(
    parameter int CLK_DIV = 8,
    parameter int DATA_W  = 24
) (
    input  logic    clk,
    input  logic    rst,
    i2s_tx_if.slave pcm,
    output logic    i2s_sck,
    output logic    i2s_ws,
    output logic    i2s_sd,
    output logic    underrun
);
    localparam int NUM_CH = 2;
    localparam int SLOT_W = 32;
    localparam int PAD    = SLOT_W - DATA_W;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]              div_cnt;
    logic [5:0]                    bit_cnt;
    logic [5:0]                    bit_nxt;
    logic [NUM_CH*SLOT_W-1:0]      sr;
    logic [NUM_CH-1:0][DATA_W-1:0] hold;
    logic [NUM_CH-1:0][DATA_W-1:0] src;
    logic [NUM_CH-1:0][SLOT_W-1:0] slot;
    logic                          hold_full;
    logic                          tick;
    logic                          fall;
    logic                          frame_load;
    logic                          in_ready;
    logic                          accept;
    logic                          ws_nxt;

    assign tick       = div_cnt == DIV_LAST;
    assign fall       = tick & i2s_sck;
    assign frame_load = fall & (bit_cnt == 6'd63);
    assign bit_nxt    = bit_cnt + 6'd1;
    // WS flips one bit before the slot it names (Philips alignment)
    assign ws_nxt     = (bit_nxt >= 6'd31) & (bit_nxt != 6'd63);

    assign in_ready     = ~hold_full | frame_load;
    assign pcm.in_ready = in_ready;
    assign accept       = pcm.in_valid & in_ready;

`ifdef I2S_TX_HOLD_LAST_EN
    logic [NUM_CH-1:0][DATA_W-1:0] last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= '0;
        end else if (frame_load && hold_full) begin
            last <= hold;
        end
    end

    assign src = hold_full ? hold : last;
`else
    assign src = hold_full ? hold : '0;
`endif

    // Index 1 is the left channel so the packed slot array is frame-ordered
    for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
        assign slot[c] = SLOT_W'(src[c]) << PAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= 6'd63;
            i2s_sck   <= 1'b0;
            i2s_ws    <= 1'b0;
            sr        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            underrun <= frame_load & ~hold_full;
            if (tick) begin
                i2s_sck <= ~i2s_sck;
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                i2s_ws  <= ws_nxt;
                sr      <= frame_load ? slot : {sr[NUM_CH*SLOT_W-2:0], 1'b0};
            end
            if (accept) begin
                hold <= {pcm.ldata, pcm.rdata};
            end
            hold_full <= accept | (hold_full & ~frame_load);
        end
    end

    assign i2s_sd = sr[NUM_CH*SLOT_W-1];
endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S master transmitter for the audio output path. It accepts stereo PCM sample pairs over a valid/ready handshake and buffers one pair. It generates the serial clock and word-select from the system clock and shifts the samples out MSB-first in Philips I2S format to an external I2S DAC or codec. It is the playback-side counterpart of the microphone I2S receiver: same slot format and clocking, opposite data direction.

## Interface
- `CLK_DIV`, 8: `clk` cycles per half-period of `i2s_sck`; legal range ≥ 2.
- `DATA_W`, 24: sample width; legal range 16..32.
- `clk` input 1: system clock, 50 MHz in the top level.
- `rst` input 1: reset; synchronous, active-high.
- `ldata` input DATA_W: left sample, two's complement.
- `rdata` input DATA_W: right sample, two's complement.
- `in_valid` input 1: `ldata`/`rdata` hold a valid pair.
- `in_ready` output 1: the block accepts the pair on this cycle.
- `i2s_sck` output 1: serial bit clock.
- `i2s_ws` output 1: word select; 0 = left, 1 = right.
- `i2s_sd` output 1: serial data.
- `underrun` output 1: one-cycle pulse when a frame starts with no new pair.

## Operation
- **Clock divider**
  - `div_cnt` counts 0..CLK_DIV-1.
  - At the terminal count, `i2s_sck` toggles.
  - A 1→0 toggle is a *fall event*.
- **Frame layout**
  - A frame is 64 SCK periods, tracked by `bit_cnt` 0..63, which increments (wraps) on each fall event.
  - Slot width is fixed at 32 bits.
  - Left slot: `bit_cnt` 0..31. Right slot: 32..63.
  - Each slot sends DATA_W bits MSB-first, then 32-DATA_W zeros.
- **Word select** leads data by one bit (Philips):
  - `i2s_ws` = 1 while `bit_cnt` ∈ 31..62.
  - `i2s_ws` = 0 for `bit_cnt` 63 and 0..30.
- **Buffering**
  - One-entry holding register `hold` with flag `hold_full`.
  - `in_ready` = ~`hold_full` | `frame_load`.
  - Accept when `in_valid` & `in_ready`: `hold` ← {ldata, rdata}, `hold_full` ← 1.
- **Frame load** is the fall event on which `bit_cnt` wraps 63→0.
  - If `hold_full`: the 64-bit shift register loads from `hold`, and `hold_full` clears unless a new pair is accepted on the same cycle.
  - Otherwise `underrun` pulses for one cycle and the shift register loads the underrun pattern (see Configuration).
  - Simultaneous load and accept is legal: the old pair goes to the shifter, the new pair goes to `hold`.
- **Serial output**: `i2s_sd` = MSB of the shift register; the register shifts left by 1 on every fall event other than a frame load.
- **Port stability**: `ldata`/`rdata` are sampled only on accept; they may change at any other time.

## Timing
- **Reset values**: `div_cnt`=0, `bit_cnt`=63, `i2s_sck`=0, `i2s_ws`=0, `i2s_sd`=0, shift register 0, `hold_full`=0, `in_ready`=1, `underrun`=0.
- **Reset mid-frame** aborts the frame immediately. Outputs take their reset values on the next edge, and the buffered pair is discarded.
- **Startup**: the first rising SCK edge comes CLK_DIV cycles after reset release. The first fall event comes 2·CLK_DIV cycles after release and is a frame load.
- **SCK edges**: `i2s_sd` and `i2s_ws` change only on fall events, registered in the same cycle as the `i2s_sck` 1→0 transition. The receiver samples them on the SCK rising edge.
- **Rates**: SCK = f_clk/(2·CLK_DIV); frame rate = f_clk/(128·CLK_DIV). Default at 50 MHz: 3.125 MHz SCK, 48.828 kHz frame rate.
- **Latency**: a pair accepted while the shifter is mid-frame starts on the next frame load. Its left MSB appears on `i2s_sd` on that fall event.
- **Back-pressure**: `in_ready` is low from accept until the next frame load, so at most one pair per frame is accepted.
- **Outputs**: all outputs are registered; no combinational input→output path except `in_ready`.

## Configuration
- Macro: `I2S_TX_HOLD_LAST_EN`.
- **Defined**: on underrun, the shift register reloads the last transmitted pair (repeat). After reset it reloads 0 until the first pair arrives.
- **Undefined**: on underrun, the shift register loads all zeros (mute).
- `underrun` pulses identically in both builds.

## Test plan
- **Reset / idle**
  - Stimulus: hold `rst` 5 cycles, no `in_valid`.
  - Required: all outputs at reset values; SCK period 16 clk cycles; `i2s_ws` high for exactly 32 SCK periods per 64.
  - Required: `underrun` pulses once per 1024 clk cycles, and `i2s_sd` stays 0.
- **Single pair**
  - Stimulus: ldata=24'hA5A5A5, rdata=24'h3C0FF0, one valid pulse.
  - Required: a receiver model sampling on rising SCK decodes left=A5A5A5, right=3C0FF0 with 8 zero pad bits per slot.
  - Required: the MSB immediately follows the WS transition by 1 SCK.
- **Back-to-back streaming**
  - Stimulus: `in_valid` held high with an incrementing counter.
  - Required: exactly one accept per frame; `in_ready` rises on the frame-load cycle; the decoded sequence is contiguous with no `underrun` after the first frame.
- **Underrun**
  - Stimulus: send 24'h123456/24'h654321, then stop.
  - Required: the next frame has `underrun`=1. It decodes 0/0 without `I2S_TX_HOLD_LAST_EN` and 123456/654321 with it.
- **Reset mid-frame**
  - Stimulus: assert `rst` at `bit_cnt`=40 with `hold_full`=1.
  - Required: next cycle `i2s_sck`=0, `i2s_ws`=0, `i2s_sd`=0, `in_ready`=1; the held pair is never transmitted.
- **Parameters**
  - Stimulus: CLK_DIV=2, DATA_W=16, ldata=16'h8001.
  - Required: SCK period 4 clk cycles; left slot bits 1000000000000001 followed by 16 zeros.
